fpu_addsub_arbiter: RTL and testbench

// - Shares one pipelined FP32 add/sub unit between NUM_REQ requesters, e.g. the FFT-8 butterfly lanes.
// - Arbitrates at most one issue per cycle and registers the operands to the unit.
// - Tracks each in-flight operation's requester ID in a tag pipeline matched to the unit's latency.
// - Routes each returned result to its requester and flags protocol mismatches.

---
 rtl/fpu_addsub_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_fpu_addsub_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_arbiter.sv
`timescale 1ns/1ps
// Shares one pipelined FP32 add/sub unit between NUM_REQ requesters and routes results back by tag.
// Define FPU_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority; round-robin otherwise.
module fpu_addsub_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_DATA = 32,
    parameter int NUM_OP    = 1,
    parameter int LATENCY   = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_flush,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*NUM_OP-1:0]     i_req_op,
    input  logic [NUM_REQ*SIZE_DATA-1:0]  i_req_a,
    input  logic [NUM_REQ*SIZE_DATA-1:0]  i_req_b,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_fpu_valid,
    output logic [NUM_OP-1:0]             o_fpu_op,
    output logic [SIZE_DATA-1:0]          o_fpu_a,
    output logic [SIZE_DATA-1:0]          o_fpu_b,
    input  logic                          i_fpu_valid,
    input  logic [SIZE_DATA-1:0]          i_fpu_result,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [SIZE_DATA-1:0]          o_rsp_data,
    output logic                          o_err
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int DROP_W = $clog2(LATENCY + 1);

    logic                 grant_any;
    logic [ID_W-1:0]      grant_id;
    logic                 issue_hs;
    logic [NUM_OP-1:0]    sel_op;
    logic [SIZE_DATA-1:0] sel_a;
    logic [SIZE_DATA-1:0] sel_b;
    logic [ID_W-1:0]      iss_id;

    logic                 tag_v  [LATENCY];
    logic [ID_W-1:0]      tag_id [LATENCY];
    logic                 tail_v;
    logic [ID_W-1:0]      tail_id;
    logic [NUM_REQ-1:0]   tail_onehot;
    logic                 rsp_match;
    logic                 mismatch;
    logic [DROP_W-1:0]    drop_cnt;

`ifdef FPU_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last (winning) assignment.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W:0]   scan_idx;

    // Scan starts at rr_ptr and wraps; the extra bit holds the unwrapped sum.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_any && i_req_valid[scan_idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else if (i_flush) begin
            rr_ptr <= '0;
        end else if (issue_hs) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end
`endif

    // Handshake: requester k transfers op/a/b in the cycle where i_req_valid[k] and
    // o_req_ready[k] are both high; ready is combinational, one-hot, and never depends
    // on ready itself. A valid requester holds its payload until that cycle.
    assign issue_hs = grant_any && !i_flush && i_rst_n;

    always_comb begin
        o_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_req_ready[k] = issue_hs && (grant_id == ID_W'(k));
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_op = i_req_op[k*NUM_OP +: NUM_OP];
                sel_a  = i_req_a[k*SIZE_DATA +: SIZE_DATA];
                sel_b  = i_req_b[k*SIZE_DATA +: SIZE_DATA];
            end
        end
    end

    // Issue stage: operand registers hold when idle so the unit sees stable inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fpu_valid <= 1'b0;
            o_fpu_op    <= '0;
            o_fpu_a     <= '0;
            o_fpu_b     <= '0;
            iss_id      <= '0;
        end else if (i_flush) begin
            o_fpu_valid <= 1'b0;
            o_fpu_op    <= '0;
            o_fpu_a     <= '0;
            o_fpu_b     <= '0;
            iss_id      <= '0;
        end else begin
            o_fpu_valid <= issue_hs;
            if (issue_hs) begin
                o_fpu_op <= sel_op;
                o_fpu_a  <= sel_a;
                o_fpu_b  <= sel_b;
                iss_id   <= grant_id;
            end
        end
    end

    // Tag pipe: stage LATENCY-1 lines up with the cycle the unit returns the result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]  <= o_fpu_valid;
            tag_id[0] <= iss_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign tail_v  = tag_v[LATENCY-1];
    assign tail_id = tag_id[LATENCY-1];

    always_comb begin
        tail_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (tail_id == ID_W'(k)) begin
                tail_onehot[k] = 1'b1;
            end
        end
    end

    // Counts down the cycles in which results of flushed operations may still arrive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_cnt <= '0;
        end else if (i_flush) begin
            drop_cnt <= DROP_W'(LATENCY);
        end else if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - DROP_W'(1);
        end
    end

    assign rsp_match = tail_v && i_fpu_valid;
    assign mismatch  = (tail_v && !i_fpu_valid) ||
                       (!tail_v && i_fpu_valid && (drop_cnt == '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else if (i_flush) begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= rsp_match ? tail_onehot : '0;
            if (rsp_match) begin
                o_rsp_data <= i_fpu_result;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err <= 1'b0;
        end else if (mismatch) begin
            o_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
`timescale 1ns/1ps
// Bench for fpu_addsub_arbiter: grant table, directed corner sequences and a randomized run
// against an FP add/sub unit stub and a scoreboard of expected responses.
module tb_fpu_addsub_arbiter;

    localparam int N       = 4;
    localparam int W       = 32;
    localparam int L       = 3;
    localparam int ENTRY_W = 72;   // {due cycle, id, data}

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [N-1:0]      req_valid;
    logic              req_op [N];
    logic [W-1:0]      req_a  [N];
    logic [W-1:0]      req_b  [N];
    logic [N-1:0]      req_op_p;
    logic [N*W-1:0]    req_a_p;
    logic [N*W-1:0]    req_b_p;
    logic [N-1:0]      o_req_ready;
    logic              o_fpu_valid;
    logic [0:0]        o_fpu_op;
    logic [W-1:0]      o_fpu_a;
    logic [W-1:0]      o_fpu_b;
    logic              i_fpu_valid;
    logic [W-1:0]      i_fpu_result;
    logic [N-1:0]      o_rsp_valid;
    logic [W-1:0]      o_rsp_data;
    logic              o_err;

    logic              stub_valid;
    logic [W-1:0]      stub_result;
    logic              inject;
    logic              stub_v_line [L];
    logic [W-1:0]      stub_d_line [L];

    int                cyc = 0;
    int                n_cmp = 0;
    int                n_fail = 0;
    logic              err_chk_en;
    logic [N-1:0]      hs_mask;
    int                m_ptr;
    int                g;
    logic              exp_iss_v;
    logic [64:0]       exp_iss;
    logic [ENTRY_W-1:0] e;
    logic [ENTRY_W-1:0] exp_q [$];

    typedef struct {
        logic [N-1:0] req;
        logic         fl;
        logic [N-1:0] exp_rr;
        logic [N-1:0] exp_fp;
    } vec_t;
    vec_t tbl [19];

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign req_op_p[k]          = req_op[k];
        assign req_a_p[k*W +: W]    = req_a[k];
        assign req_b_p[k*W +: W]    = req_b[k];
    end

    assign i_fpu_valid  = stub_valid | inject;
    assign i_fpu_result = stub_result;

    fpu_addsub_arbiter #(
        .NUM_REQ(N), .SIZE_DATA(W), .NUM_OP(1), .LATENCY(L)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_req_valid(req_valid), .i_req_op(req_op_p), .i_req_a(req_a_p), .i_req_b(req_b_p),
        .o_req_ready(o_req_ready),
        .o_fpu_valid(o_fpu_valid), .o_fpu_op(o_fpu_op), .o_fpu_a(o_fpu_a), .o_fpu_b(o_fpu_b),
        .i_fpu_valid(i_fpu_valid), .i_fpu_result(i_fpu_result),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_err(o_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic (integer-valued floats) ----------------
    function automatic logic [W-1:0] int_to_fp(input int v);
        int m;
        int ex;
        logic s;
        if (v == 0) return '0;
        s  = (v < 0);
        m  = s ? -v : v;
        ex = 0;
        while ((m >> (ex + 1)) != 0) ex++;
        return {s, 8'(ex + 127), 23'(m << (23 - ex))};
    endfunction

    function automatic int fp_to_int(input logic [W-1:0] f);
        int ex;
        int m;
        int v;
        if (f[30:0] == 31'd0) return 0;
        ex = int'(f[30:23]) - 127;
        m  = int'({1'b1, f[22:0]});
        if (ex < 0)       v = 0;
        else if (ex > 23) v = m << (ex - 23);
        else              v = m >> (23 - ex);
        return f[31] ? -v : v;
    endfunction

    function automatic logic [W-1:0] fp_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        int x;
        int y;
        x = fp_to_int(a);
        y = fp_to_int(b);
        return int_to_fp(op ? (x - y) : (x + y));
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] r;
        r = '0;
        if (k >= 0 && k < N) r[k] = 1'b1;
        return r;
    endfunction

    // Requester served next: the valid one closest after the last served (or lowest index).
    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        int best;
        int best_d;
        int d;
        best   = -1;
        best_d = N;
        for (int k = 0; k < N; k++) begin
            if (v[k]) begin
`ifdef FPU_ARB_FIXED_PRIO_EN
                d = k + 0 * ptr;
`else
                d = (k - ptr + N) % N;
`endif
                if (d < best_d) begin
                    best_d = d;
                    best   = k;
                end
            end
        end
        return best;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- add/sub unit stub: result LATENCY cycles after issue ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin
                stub_v_line[k] = 1'b0;
                stub_d_line[k] = '0;
            end
            stub_valid  = 1'b0;
            stub_result = '0;
        end else begin
            stub_valid  = stub_v_line[L-1];
            stub_result = stub_d_line[L-1];
            for (int k = L - 1; k > 0; k--) begin
                stub_v_line[k] = stub_v_line[k-1];
                stub_d_line[k] = stub_d_line[k-1];
            end
            stub_v_line[0] = o_fpu_valid;
            stub_d_line[0] = fp_op(o_fpu_op[0], o_fpu_a, o_fpu_b);
        end
    end

    // ---------------- monitor, model and scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            m_ptr     = 0;
            exp_iss_v = 1'b0;
            exp_iss   = '0;
            hs_mask   = '0;
            exp_q.delete();
        end else begin
            hs_mask = req_valid & o_req_ready;
            g = flush ? -1 : model_grant(req_valid, m_ptr);
            check("grant", o_req_ready, onehot(g));
            check("issue_valid", o_fpu_valid, exp_iss_v);
            if (exp_iss_v) check("issue_operands", {o_fpu_op, o_fpu_a, o_fpu_b}, exp_iss);
            if (o_rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", o_rsp_valid, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", cyc, e[71:40]);
                    check("rsp_id", o_rsp_valid, onehot(int'(e[39:32])));
                    check("rsp_data", o_rsp_data, e[31:0]);
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][71:40]) <= cyc) begin
                e = exp_q.pop_front();
                check("rsp_missing", o_rsp_valid, onehot(int'(e[39:32])));
            end
            if (err_chk_en) check("err_clear", o_err, 1'b0);
            if (flush) begin
                m_ptr     = 0;
                exp_iss_v = 1'b0;
                exp_q.delete();
            end else if (g >= 0) begin
                exp_q.push_back({32'(cyc + L + 2), 8'(g), fp_op(req_op[g], req_a[g], req_b[g])});
                exp_iss_v = 1'b1;
                exp_iss   = {req_op[g], req_a[g], req_b[g]};
                m_ptr     = (g + 1) % N;
            end else begin
                exp_iss_v = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_op(input int k);
        req_valid[k] = 1'b1;
        req_op[k]    = 1'($urandom_range(0, 1));
        req_a[k]     = int_to_fp(int'($urandom_range(0, 4000)) - 2000);
        req_b[k]     = int_to_fp(int'($urandom_range(0, 4000)) - 2000);
    endtask

    // Pending (valid, ungranted) requests keep their payload; others get a fresh one.
    task automatic drive_mask(input logic [N-1:0] mask, input logic fl);
        for (int k = 0; k < N; k++) begin
            if (mask[k]) begin
                if (!(req_valid[k] && !hs_mask[k])) new_op(k);
            end else begin
                req_valid[k] = 1'b0;
            end
        end
        flush = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            req_valid = '0;
            flush     = 1'b0;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0; flush = 1'b0; inject = 1'b0; err_chk_en = 1'b1;
        req_valid = '0;
        for (int k = 0; k < N; k++) new_op(k);

        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 4'b0001};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0010, 4'b0001};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0100, 4'b0001};
        tbl[4]  = '{4'b1111, 1'b0, 4'b1000, 4'b0001};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0001, 4'b0001};
        tbl[6]  = '{4'b1111, 1'b0, 4'b0010, 4'b0001};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0100, 4'b0001};
        tbl[8]  = '{4'b1111, 1'b0, 4'b1000, 4'b0001};
        tbl[9]  = '{4'b1111, 1'b0, 4'b0001, 4'b0001};
        tbl[10] = '{4'b1111, 1'b1, 4'b0000, 4'b0000};
        tbl[11] = '{4'b1111, 1'b0, 4'b0001, 4'b0001};
        tbl[12] = '{4'b1100, 1'b0, 4'b0100, 4'b0100};
        tbl[13] = '{4'b0101, 1'b0, 4'b0001, 4'b0001};
        tbl[14] = '{4'b1000, 1'b0, 4'b1000, 4'b1000};
        tbl[15] = '{4'b0110, 1'b0, 4'b0010, 4'b0010};
        tbl[16] = '{4'b0110, 1'b0, 4'b0100, 4'b0010};
        tbl[17] = '{4'b0011, 1'b0, 4'b0001, 4'b0001};
        tbl[18] = '{4'b0000, 1'b0, 4'b0000, 4'b0000};

        // Reset held with every requester asking.
        req_valid = '1;
        #12;
        check("reset_ready", o_req_ready, '0);
        check("reset_fpu_valid", o_fpu_valid, 1'b0);
        check("reset_rsp_valid", o_rsp_valid, '0);
        check("reset_err", o_err, 1'b0);
        check("reset_fpu_a", o_fpu_a, '0);
        tick();
        rst_n = 1'b1;
        req_valid = '0;
        tick();

        // Grant table: round-robin order, flush returning the pointer to 0, wrap cases.
        for (int i = 0; i < 19; i++) begin
            tick();
            drive_mask(tbl[i].req, tbl[i].fl);
            @(negedge clk);
`ifdef FPU_ARB_FIXED_PRIO_EN
            check($sformatf("table_grant_%0d", i), o_req_ready, tbl[i].exp_fp);
`else
            check($sformatf("table_grant_%0d", i), o_req_ready, tbl[i].exp_rr);
`endif
        end
        idle(L + 4);

        // Single add on requester 1: 1.0 + 2.0 = 3.0, response LATENCY+2 after the grant.
        tick();
        req_valid = '0;
        req_valid[1] = 1'b1; req_op[1] = 1'b0;
        req_a[1] = 32'h3F800000; req_b[1] = 32'h40000000;
        @(negedge clk);
        check("single_ready", o_req_ready, 4'b0010);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("single_issue", {o_fpu_valid, o_fpu_op, o_fpu_a, o_fpu_b}, {1'b1, 1'b0, 32'h3F800000, 32'h40000000});
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        check("single_rsp_valid", o_rsp_valid, 4'b0010);
        check("single_rsp_data", o_rsp_data, 32'h40400000);
        tick();
        @(negedge clk);
        check("single_rsp_pulse", o_rsp_valid, 4'b0000);
        idle(L + 2);

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (!(req_valid[k] && !hs_mask[k])) begin
                    if ($urandom_range(0, 99) < 60) new_op(k);
                    else req_valid[k] = 1'b0;
                end
            end
            flush = ($urandom_range(0, 29) == 0);
        end
        idle(L + 5);
        check("scoreboard_drained", 96'(exp_q.size()), 96'd0);

        // Result strobe with nothing in flight sets the sticky error.
        err_chk_en = 1'b0;
        @(negedge clk);
        check("pre_inject_err", o_err, 1'b0);
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge clk);
        check("mismatch_err_set", o_err, 1'b1);
        check("mismatch_no_rsp", o_rsp_valid, '0);
        idle(5);
        @(negedge clk);
        check("mismatch_err_sticky", o_err, 1'b1);

        // Reset again with all requesters asking.
        tick();
        for (int k = 0; k < N; k++) new_op(k);
        rst_n = 1'b0;
        #1;
        check("reset2_ready", o_req_ready, '0);
        check("reset2_err", o_err, 1'b0);
        check("reset2_fpu_valid", o_fpu_valid, 1'b0);
        check("reset2_rsp_valid", o_rsp_valid, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
